pnr_sysbus_master: RTL and testbench

System-bus initiator for the PNR subsystem. It is the other end of the register-bank protocol: it takes single read/write commands over a valid/ready command port and drives `sys_addr`/`sys_wdata`/`sys_wen`/`sys_ren`. It then waits for `sys_ack` with a timeout and returns data and status over a valid/ready response port. It sits between an on-chip sequencer (calibration/threshold sweep) and the system-bus fabric that the PNR register slaves are attached to.

---
 rtl/pnr_sysbus_master.sv | 143 ++++++++++++++
 tb/tb_pnr_sysbus_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pnr_sysbus_master.sv
// pnr_sysbus_master: single-outstanding system-bus initiator.
// Takes read/write commands on a valid/ready port and issues a one-cycle
// strobe on the system bus. It then waits for sys_ack, or gives up after
// TIMEOUT cycles, and returns the read data and status on a valid/ready
// response port.
module pnr_sysbus_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [31:0] sys_addr,
    output logic [31:0] sys_wdata,
    output logic        sys_wen,
    output logic        sys_ren,
    input  logic [31:0] sys_rdata,
    input  logic        sys_err,
    input  logic        sys_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    // cnt holds (cycle - 1) while in WAIT, counting the strobe cycle as
    // cycle 1. The wait therefore gives up in the cycle numbered TIMEOUT,
    // and the response appears in cycle TIMEOUT+1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic             accept;
    logic             ack_take;
    logic             to_take;
    logic             rsp_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_STROBE;
            S_STROBE: state_nxt = ack_take ? S_RESP : S_WAIT;
            S_WAIT:   if (ack_take || to_take) state_nxt = S_RESP;
            S_RESP:   if (rsp_done) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Handshake and event decode; ack is only honoured while a strobe is outstanding
    always_comb begin
        cmd_ready = (state == S_IDLE) && rstn_i;
        accept    = cmd_valid && cmd_ready;
        ack_take  = sys_ack && ((state == S_STROBE) || (state == S_WAIT));
        to_take   = (state == S_WAIT) && !sys_ack && (cnt >= CNT_LAST);
        rsp_done  = (state == S_RESP) && rsp_ready;
    end

    // Bus-side registers: address/data latched on accept, strobes last one cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sys_addr  <= '0;
            sys_wdata <= '0;
            sys_wen   <= 1'b0;
            sys_ren   <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            sys_wen <= accept && cmd_write;
            sys_ren <= accept && !cmd_write;
            if (accept) begin
                sys_addr  <= cmd_addr;
                sys_wdata <= cmd_wdata;
                wr_q      <= cmd_write;
            end
        end
    end

    // Ack-wait counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == S_STROBE) begin
            cnt <= CNT_W'(1);
        end else if ((state == S_WAIT) && !ack_take && !to_take) begin
            cnt <= sat_inc(cnt);
        end
    end

    // Response capture; fields stay untouched until the next capture
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rsp_valid <= (state_nxt == S_RESP);
            busy      <= (state_nxt != S_IDLE);
            if (ack_take) begin
                rsp_rdata   <= wr_q ? 32'h0 : sys_rdata;
                rsp_err     <= sys_err;
                rsp_timeout <= 1'b0;
            end else if (to_take) begin
                rsp_rdata   <= 32'h0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pnr_sysbus_master.sv
// Testbench for pnr_sysbus_master: directed and randomized transactions
// checked against a cycle-count/result model derived from the bus rules.
module tb_pnr_sysbus_master;

    localparam int TO = 64;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    int checks = 0;
    int errors = 0;

    logic        nxt_wr;
    logic [31:0] nxt_addr;
    logic [31:0] nxt_wd;

    pnr_sysbus_master #(.TIMEOUT(TO)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_wen    (sys_wen),
        .sys_ren    (sys_ren),
        .sys_rdata  (sys_rdata),
        .sys_err    (sys_err),
        .sys_ack    (sys_ack)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction. Entered at posedge+1 of cycle 0, returns at posedge+1
    // of the cycle after the response handshake. ack_cyc = 0 means never.
    // The slave acks in cycle ack_cyc. The sequencer holds rsp_ready low for
    // 'hold' cycles of the response. With bp set, the next command (nxt_*)
    // is offered throughout the transaction.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_cyc, input logic [31:0] srd, input bit serr,
                           input int hold, input bit bp);
        bit          acked;
        int          exp_c;
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          exp_to;
        int          first;
        int          extra;
        int          rdy_bad;
        bit          done;
        acked   = (ack_cyc >= 1) && (ack_cyc <= TO);
        exp_c   = acked ? ack_cyc + 1 : TO + 1;
        exp_rd  = (acked && !wr) ? srd : 32'h0;
        exp_err = acked ? serr : 1'b1;
        exp_to  = !acked;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        rsp_ready = 1'b0; sys_ack = 1'b0;
        @(negedge clk_i);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk_i); #1;
        first = -1; extra = 0; rdy_bad = 0; done = 0;
        for (int c = 1; (c <= exp_c + hold + 4) && !done; c++) begin
            if (bp) begin
                cmd_valid = 1'b1; cmd_write = nxt_wr; cmd_addr = nxt_addr; cmd_wdata = nxt_wd;
            end else begin
                cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
            end
            sys_ack   = (c == ack_cyc);
            sys_rdata = (c == ack_cyc) ? srd : $urandom;
            sys_err   = (c == ack_cyc) ? serr : 1'($urandom);
            rsp_ready = (c >= exp_c + hold);
            @(negedge clk_i);
            if (c == 1) begin
                check("strobe_wen", 32'(sys_wen), 32'(wr));
                check("strobe_ren", 32'(sys_ren), 32'(!wr));
                check("strobe_addr", sys_addr, addr);
                if (wr) check("strobe_wdata", sys_wdata, wd);
                check("busy_strobe", 32'(busy), 32'd1);
            end else if (sys_wen || sys_ren) begin
                extra++;
            end
            if (cmd_ready) rdy_bad++;
            if (rsp_valid) begin
                if (first < 0) begin
                    first = c;
                    check("rsp_cycle", 32'(c), 32'(exp_c));
                end
                check("rsp_rdata", rsp_rdata, exp_rd);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
                check("addr_held", sys_addr, addr);
                if (rsp_ready) done = 1;
            end
            @(posedge clk_i); #1;
        end
        check("rsp_handshake_seen", 32'(done), 32'd1);
        check("extra_strobes", 32'(extra), 32'd0);
        check("cmd_ready_while_busy", 32'(rdy_bad), 32'd0);
        sys_ack = 1'b0; rsp_ready = 1'b0;
        if (!bp) cmd_valid = 1'b0;
    endtask

    // Start a read, pulse reset low in cycle at_cyc, then restart and run a read.
    task automatic reset_mid(input int at_cyc);
        logic [31:0] a;
        a = $urandom;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_wdata = 32'h0;
        @(posedge clk_i); #1;
        cmd_valid = 1'b0;
        for (int c = 1; c < at_cyc; c++) begin
            @(posedge clk_i); #1;
        end
        check("busy_before_reset", 32'(busy), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("rst_ren", 32'(sys_ren), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        sys_ack = 1'b1; sys_rdata = $urandom;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        sys_ack = 1'b0;
        rstn_i = 1'b1;
        #1;
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        #1;
        run_txn(1'b0, 32'h0000_0020, 32'h0, 2, 32'h1234_5678, 1'b0, 0, 1'b0);
    endtask

    initial begin
        bit          wr;
        int          sel;
        int          ack;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] r;
        rstn_i = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; sys_rdata = '0; sys_err = 1'b0; sys_ack = 1'b0;
        nxt_wr = 1'b0; nxt_addr = '0; nxt_wd = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_strobes", {30'd0, sys_wen, sys_ren}, 32'd0);
        check("reset_sys_addr", sys_addr, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_flags", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        rstn_i = 1'b1;

        // Registered-ack slave: write, read, read with slave error
        run_txn(1'b1, 32'h0000_0004, 32'h0000_0001, 2, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0018, 32'h0, 2, 32'h0000_0064, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0040, 32'h0, 2, 32'hCAFE_0001, 1'b1, 0, 1'b0);

        // Timeout boundary: never, exactly at TIMEOUT, one past TIMEOUT
        run_txn(1'b0, 32'h0000_0080, 32'h0, 0, 32'h0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0084, 32'h0, TO, 32'h0BAD_F00D, 1'b0, 0, 1'b0);
        run_txn(1'b1, 32'h0000_0088, 32'h5555_AAAA, TO + 1, 32'h0, 1'b0, 0, 1'b0);

        // Combinational ack, then a spurious ack in IDLE
        run_txn(1'b0, 32'h0000_0010, 32'h0, 1, 32'hA5A5_0010, 1'b0, 0, 1'b0);
        sys_ack = 1'b1; sys_err = 1'b1; sys_rdata = $urandom;
        @(negedge clk_i);
        check("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk_i); #1;
        sys_ack = 1'b0;
        @(negedge clk_i);
        check("late_ack_no_rsp", 32'(rsp_valid), 32'd0);
        check("late_ack_idle", 32'(busy), 32'd0);
        @(posedge clk_i); #1;

        // Back-pressure with the next command already offered
        nxt_wr = 1'b1; nxt_addr = 32'h0000_0100; nxt_wd = 32'h0F0F_1234;
        run_txn(1'b0, 32'h0000_00FC, 32'h0, 2, 32'h7777_0001, 1'b0, 10, 1'b1);
        run_txn(nxt_wr, nxt_addr, nxt_wd, 2, 32'h0, 1'b0, 0, 1'b0);

        // Reset during WAIT and during STROBE
        reset_mid(3);
        reset_mid(1);

        // Randomized transactions
        for (int i = 0; i < 20; i++) begin
            wr  = 1'($urandom);
            a   = $urandom;
            d   = $urandom;
            r   = $urandom;
            sel = $urandom_range(0, 3);
            ack = (sel == 0) ? 1 : (sel == 1) ? 2 : (sel == 2) ? $urandom_range(3, TO + 3) : 0;
            run_txn(wr, a, d, ack, r, 1'($urandom), $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
